// File: rtl/mult32x32_ctrl.sv
// mult32x32_ctrl: step sequencer for the 32x32 byte-by-halfword multiplier datapath.
// Latency: start accepted in cycle 0, product updates in cycles 1..8, done pulse in cycle 9.
// Handshake: start is taken only when idle; abort cancels a running operation with no done pulse.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   start_i, abort_i      request / cancel toward the requester
//   a_i, b_i              operand buses (read only by the zero-skip option)
//   busy_o, done_o        status toward the requester
//   a_sel_o, b_sel_o      byte of A / halfword of B for the current partial product
//   shift_sel_o           partial-product shift code (8*code bits), 3'b111 adds nothing
//   upd_prod_o            accumulate shifted partial product into the product register
//   clr_prod_o            clear the product register (only when AUTO_CLEAR=1)
//
// Optional build macro ZERO_SKIP_EN: steps whose selected A byte or B halfword is zero
// are skipped, so the operation takes one cycle per nonzero step.
`timescale 1ns/1ps
module mult32x32_ctrl #(
  parameter bit AUTO_CLEAR = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [1:0]  a_sel_o,
  output logic        b_sel_o,
  output logic [2:0]  shift_sel_o,
  output logic        upd_prod_o,
  output logic        clr_prod_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t      state_q;
  logic [2:0]  k_q;
  logic        busy_q;
  logic        done_q;
  logic [1:0]  a_sel_q;
  logic        b_sel_q;
  logic [2:0]  shift_q;
  logic        upd_q;

  // {found, step}: first step to run after accept, and step to run after k_q
  logic [3:0]  first_step_d;
  logic [3:0]  next_step_d;

  // A byte index contributes 8*a_sel, B halfword index contributes 16*b_sel.
  function automatic logic [2:0] shift_code(input logic [2:0] k);
    return {1'b0, k[1:0]} + {1'b0, k[2], 1'b0};
  endfunction

`ifdef ZERO_SKIP_EN
  // Smallest step >= from whose A byte and B halfword are both nonzero.
  function automatic logic [3:0] find_live(input logic [3:0]  from,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [3:0] r;
    r = 4'b0000;
    for (int j = 7; j >= 0; j--) begin
      if ((j >= int'(from)) && (a[8*(j%4) +: 8] != 8'd0) && (b[16*(j/4) +: 16] != 16'd0))
        r = {1'b1, 3'(j)};
    end
    return r;
  endfunction

  assign first_step_d = find_live(4'd0, a_i, b_i);
  assign next_step_d  = find_live({1'b0, k_q} + 4'd1, a_i, b_i);
`else
  assign first_step_d = 4'b1000;
  assign next_step_d  = {k_q != 3'd7, k_q + 3'd1};

  // Operand buses only matter for zero-skip.
  logic unused_ab;
  assign unused_ab = ^{a_i, b_i};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_sel_q <= 2'd0;
      b_sel_q <= 1'b0;
      shift_q <= 3'b111;
      upd_q   <= 1'b0;
    end else begin
      // Idle encodings unless a step is loaded below.
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_sel_q <= 2'd0;
      b_sel_q <= 1'b0;
      shift_q <= 3'b111;
      upd_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (first_step_d[3]) begin
              state_q <= ST_RUN;
              k_q     <= first_step_d[2:0];
              busy_q  <= 1'b1;
              upd_q   <= 1'b1;
              a_sel_q <= first_step_d[1:0];
              b_sel_q <= first_step_d[2];
              shift_q <= shift_code(first_step_d[2:0]);
            end else begin
              state_q <= ST_DONE;
              k_q     <= 3'd0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (abort_i) begin
            state_q <= ST_IDLE;
            k_q     <= 3'd0;
          end else if (next_step_d[3]) begin
            k_q     <= next_step_d[2:0];
            busy_q  <= 1'b1;
            upd_q   <= 1'b1;
            a_sel_q <= next_step_d[1:0];
            b_sel_q <= next_step_d[2];
            shift_q <= shift_code(next_step_d[2:0]);
          end else begin
            state_q <= ST_DONE;
            k_q     <= 3'd0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          k_q     <= 3'd0;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign a_sel_o     = a_sel_q;
  assign b_sel_o     = b_sel_q;
  assign shift_sel_o = shift_q;
  // An aborted step must not land in the product register, even in its own cycle.
  assign upd_prod_o  = upd_q & ~abort_i;
  // Clear is issued in the accept cycle itself; masked during reset so reset alone never clears.
  assign clr_prod_o  = AUTO_CLEAR & ~reset & start_i & (state_q == ST_IDLE);

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Bench for mult32x32_ctrl: two instances (AUTO_CLEAR=1 and AUTO_CLEAR=0) share stimulus,
// each with a simple product-register datapath attached; a schedule model predicts all
// outputs every cycle and directed vectors pin sequences, cycle counts and products.
`timescale 1ns/1ps
module tb_mult32x32_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        dp_clr2 = 1'b0;

  logic        busy1, done1, bs1, upd1, clr1;
  logic [1:0]  as1;
  logic [2:0]  sh1;
  logic        busy2, done2, bs2, upd2, clr2;
  logic [1:0]  as2;
  logic [2:0]  sh2;

  logic [63:0] prod1 = 64'd0;
  logic [63:0] prod2 = 64'd0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int done_log[$];

`ifdef ZERO_SKIP_EN
  localparam int OFS_LOW = 2;   // only step 0 live
  localparam int OFS_ZERO = 1;  // nothing live
`else
  localparam int OFS_LOW = 9;
  localparam int OFS_ZERO = 9;
`endif

  mult32x32_ctrl #(.AUTO_CLEAR(1'b1)) dut1 (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .a_i(a), .b_i(b),
    .busy_o(busy1), .done_o(done1), .a_sel_o(as1), .b_sel_o(bs1), .shift_sel_o(sh1),
    .upd_prod_o(upd1), .clr_prod_o(clr1));

  mult32x32_ctrl #(.AUTO_CLEAR(1'b0)) dut2 (
    .clk(clk), .reset(reset), .start_i(start), .abort_i(abort), .a_i(a), .b_i(b),
    .busy_o(busy2), .done_o(done2), .a_sel_o(as2), .b_sel_o(bs2), .shift_sel_o(sh2),
    .upd_prod_o(upd2), .clr_prod_o(clr2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath: selected byte times selected halfword, shifted by 8*code.
  function automatic logic [63:0] pp(input logic [31:0] av, input logic [31:0] bv,
                                     input logic [1:0] s_a, input logic s_b, input logic [2:0] sh);
    logic [63:0] p;
    p = 64'(av[8*int'(s_a) +: 8]) * 64'(bv[16*int'(s_b) +: 16]);
    return (sh == 3'b111) ? 64'd0 : (p << (8*int'(sh)));
  endfunction

  always_ff @(posedge clk) begin
    if (clr1) prod1 <= 64'd0;
    else if (upd1) prod1 <= prod1 + pp(a, b, as1, bs1, sh1);
    if (dp_clr2 || clr2) prod2 <= 64'd0;
    else if (upd2) prod2 <= prod2 + pp(a, b, as2, bs2, sh2);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model: per-operation output schedule ----------------
  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] as;
    logic       bs;
    logic [2:0] sh;
    logic       upd;
    logic       clr;
  } out_t;

  localparam out_t IDLE_OUT = '{busy:1'b0, done:1'b0, as:2'd0, bs:1'b0, sh:3'b111, upd:1'b0, clr:1'b0};

  out_t expq[$];

  function automatic logic step_live(input int j, input logic [31:0] av, input logic [31:0] bv);
`ifdef ZERO_SKIP_EN
    return (((av >> (8*(j%4))) & 32'hFF) != 0) && (((bv >> (16*(j/4))) & 32'hFFFF) != 0);
`else
    return 1'b1;
`endif
  endfunction

  task automatic plan(input logic [31:0] av, input logic [31:0] bv);
    out_t r;
    for (int j = 0; j < 8; j++) begin
      if (step_live(j, av, bv)) begin
        r = IDLE_OUT;
        r.busy = 1'b1;
        r.upd  = 1'b1;
        r.as   = 2'(j % 4);
        r.bs   = 1'(j / 4);
        r.sh   = 3'((j % 4) + 2*(j / 4));
        expq.push_back(r);
      end
    end
    r = IDLE_OUT;
    r.done = 1'b1;
    expq.push_back(r);
  endtask

  always @(negedge clk) begin
    out_t e, g1, g2;
    e = IDLE_OUT;
    if (reset) begin
      expq.delete();
    end else if (expq.size() == 0) begin
      if (start) begin
        e.clr = 1'b1;
        plan(a, b);
      end
    end else begin
      e = expq.pop_front();
      if (e.busy && abort) begin
        e.upd = 1'b0;
        expq.delete();
      end
    end
    g1 = {busy1, done1, as1, bs1, sh1, upd1, clr1};
    g2 = {busy2, done2, as2, bs2, sh2, upd2, clr2};
    chk("model_outs_ac1", 64'(g1), 64'(e));
    e.clr = 1'b0;
    chk("model_outs_ac0", 64'(g2), 64'(e));
    if (done1) done_log.push_back(cyc);
  end

  // ---------------- directed vectors ----------------
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic with_abort,
                        output int dofs, output logic [63:0] p1, output logic [63:0] p2);
    a = av; b = bv; start = 1'b1; abort = with_abort;
    dofs = -1; p1 = 64'd0; p2 = 64'd0;
    tick(1);
    start = 1'b0; abort = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (done1) begin
        dofs = i; p1 = prod1; p2 = prod2;
        break;
      end
      tick(1);
    end
    tick(1);
  endtask

  task automatic full_sweep(input string tag);
    logic [1:0] as_tab [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic       bs_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] sh_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd5};
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    #1;
    chk({tag, "_clr_c0"}, 64'({clr1, clr2, busy1}), 64'(3'b100));
    tick(1);
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_step"}, 64'({as1, bs1, sh1, upd1, busy1, done1}),
          64'({as_tab[k], bs_tab[k], sh_tab[k], 1'b1, 1'b1, 1'b0}));
      tick(1);
    end
    chk({tag, "_done_c9"}, 64'({done1, busy1, upd1}), 64'(3'b100));
    chk({tag, "_prod"}, prod1, 64'hFFFF_FFFE_0000_0001);
    tick(1);
    chk({tag, "_done_c10"}, 64'(done1), 64'd0);
  endtask

  initial begin
    int dofs, t0;
    logic [63:0] p1, p2;

    // reset state
    tick(2);
    chk("reset_outs", 64'({busy1, done1, as1, bs1, sh1, upd1, clr1}), 64'(10'b00_00_0_111_0_0));
    reset = 1'b0;
    tick(2);
    chk("idle_outs", 64'({busy1, done1, sh1, upd1, clr1}), 64'(7'b00_111_00));

    // full sweep with all bytes nonzero
    full_sweep("sweep");

    // start held high: operations back to back every 10 cycles
    done_log.delete();
    start = 1'b1; t0 = cyc;
    tick(30);
    start = 1'b0;
    tick(12);
    chk("held_done_count", 64'(done_log.size()), 64'd3);
    if (done_log.size() == 3) begin
      chk("held_done0", 64'(done_log[0] - t0), 64'd9);
      chk("held_done1", 64'(done_log[1] - t0), 64'd19);
      chk("held_done2", 64'(done_log[2] - t0), 64'd29);
    end

    // abort during step 3
    done_log.delete();
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    abort = 1'b1;
    #1;
    chk("abort_c4", 64'({upd1, busy1, as1}), 64'({1'b0, 1'b1, 2'd3}));
    tick(1);
    abort = 1'b0;
    chk("abort_c5_idle", 64'({busy1, upd1, sh1}), 64'({1'b0, 1'b0, 3'b111}));
    chk("abort_prod", prod1, 64'h0000_00FF_FEFF_0001);
    tick(12);
    chk("abort_no_done", 64'(done_log.size()), 64'd0);

    // reset in the middle of step 5, then a clean sweep
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    chk("pre_reset_step5", 64'({busy1, as1, bs1}), 64'({1'b1, 2'd1, 1'b1}));
    #2 reset = 1'b1;
    #1;
    chk("midreset_outs", 64'({busy1, done1, as1, bs1, sh1, upd1, clr1}), 64'(10'b00_00_0_111_0_0));
    tick(1);
    reset = 1'b0;
    tick(2);
    full_sweep("post_reset");
    tick(1);

    // MAC instance accumulates; start together with abort in idle still starts
    dp_clr2 = 1'b1;
    tick(1);
    dp_clr2 = 1'b0;
    run_op(32'd3, 32'd5, 1'b1, dofs, p1, p2);
    chk("mac1_ofs", 64'(dofs), 64'(OFS_LOW));
    chk("mac1_prod_ac0", p2, 64'd15);
    chk("mac1_prod_ac1", p1, 64'd15);
    run_op(32'd7, 32'd11, 1'b0, dofs, p1, p2);
    chk("mac2_ofs", 64'(dofs), 64'(OFS_LOW));
    chk("mac2_prod_ac0", p2, 64'd92);
    chk("mac2_prod_ac1", p1, 64'd77);

    // sparse operands
    run_op(32'h0000_00FF, 32'h0000_FFFF, 1'b0, dofs, p1, p2);
    chk("sparse_ofs", 64'(dofs), 64'(OFS_LOW));
    chk("sparse_prod", p1, 64'h0000_0000_00FE_FF01);
    run_op(32'd0, 32'h1234_5678, 1'b0, dofs, p1, p2);
    chk("zero_ofs", 64'(dofs), 64'(OFS_ZERO));
    chk("zero_prod", p1, 64'd0);
    run_op(32'h8000_0001, 32'hFFFF_0000, 1'b0, dofs, p1, p2);
    chk("mixed_prod", p1, 64'h7FFF_8000_FFFF_0000);

    tick(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
